// File: rtl/axis_cmd_sequencer_if.sv
// axis_cmd_sequencer_if: host command stream plus the batch instruction/parameter bus to the BRAM load/unload block.
interface axis_cmd_sequencer_if;
  logic [63:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic [7:0]  Instruction_code;
  logic [4:0]  wr_bram_start;
  logic [4:0]  wr_bram_end;
  logic [15:0] wr_addr_start;
  logic [15:0] wr_addr_count;
  logic [2:0]  rd_bram_start;
  logic [2:0]  rd_bram_end;
  logic [15:0] rd_addr_start;
  logic [15:0] rd_addr_count;
  logic        write_done;
  logic        read_done;
  modport master (
    input  cmd_tdata, cmd_tvalid, write_done, read_done,
    output cmd_tready, Instruction_code, wr_bram_start, wr_bram_end, wr_addr_start, wr_addr_count,
    output rd_bram_start, rd_bram_end, rd_addr_start, rd_addr_count
  );
  modport slave (
    output cmd_tdata, cmd_tvalid, write_done, read_done,
    input  cmd_tready, Instruction_code, wr_bram_start, wr_bram_end, wr_addr_start, wr_addr_count,
    input  rd_bram_start, rd_bram_end, rd_addr_start, rd_addr_count
  );
endinterface

// File: rtl/axis_cmd_sequencer.sv
// axis_cmd_sequencer: queues host batch commands and issues them one at a time to the BRAM load/unload block.
module axis_cmd_sequencer #(
  parameter int CMD_DEPTH      = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       aclk,
  input  logic                       areset,
  axis_cmd_sequencer_if.master       bus,
  input  logic                       clear_err,
  output logic                       busy,
  output logic [$clog2(CMD_DEPTH):0] cmd_count,
  output logic                       cmd_done,
  output logic                       err_invalid,
  output logic                       err_timeout
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  typedef enum logic [2:0] {IDLE, CHECK, WAIT, GAP, ERROR} state_e;
  state_e state_q, state_d;
  logic [49:0] fifo_q [CMD_DEPTH];
  logic [49:0] cmd_q, cmd_d;
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0] ic_q, ic_d;
  logic [4:0] wbs_q, wbs_d, wbe_q, wbe_d;
  logic [2:0] rbs_q, rbs_d, rbe_q, rbe_d;
  logic [15:0] was_q, was_d, wac_q, wac_d, ras_q, ras_d, rac_q, rac_d;
  logic done_q, done_d, einv_q, einv_d, etmo_q, etmo_d;
  logic empty, push, pop, is_wr, is_rd, ok, hit, tmo_hit;
  logic [7:0] op;
  logic [4:0] bs, be;
  logic [15:0] ast, acn;
  logic unused_bits;
  assign unused_bits = ^{bus.cmd_tdata[55:53], bus.cmd_tdata[47:45], bus.cmd_tdata[39:32]};
  assign empty = cnt_q == '0;
  assign bus.cmd_tready = !areset && cnt_q != (AW+1)'(CMD_DEPTH);
  assign push = bus.cmd_tvalid && bus.cmd_tready;
  assign pop = state_q == IDLE && !empty;
  // cmd_q keeps the command for its whole life, so decode also selects which done to wait for
  assign {op, bs, be, ast, acn} = cmd_q;
  assign is_wr = op == 8'h01;
  assign is_rd = op == 8'h02;
  assign ok = be >= bs && (is_wr ? be <= 5'd15 : is_rd && be <= 5'd7 && bs <= 5'd7);
  assign hit = is_wr ? bus.write_done : bus.read_done;
  assign tmo_hit = TIMEOUT_CYCLES != 0 && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  assign bus.Instruction_code = ic_q;
  assign bus.wr_bram_start = wbs_q;
  assign bus.wr_bram_end = wbe_q;
  assign bus.wr_addr_start = was_q;
  assign bus.wr_addr_count = wac_q;
  assign bus.rd_bram_start = rbs_q;
  assign bus.rd_bram_end = rbe_q;
  assign bus.rd_addr_start = ras_q;
  assign bus.rd_addr_count = rac_q;
  assign busy = state_q != IDLE || !empty;
  assign cmd_count = cnt_q;
  assign cmd_done = done_q;
  assign err_invalid = einv_q;
  assign err_timeout = etmo_q;
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    ic_d = ic_q;
    {wbs_d, wbe_d, was_d, wac_d} = {wbs_q, wbe_q, was_q, wac_q};
    {rbs_d, rbe_d, ras_d, rac_d} = {rbs_q, rbe_q, ras_q, rac_q};
    done_d = 1'b0;
    einv_d = einv_q && !clear_err;
    etmo_d = etmo_q;
    gap_d = '0;
    tmo_d = '0;
    case (state_q)
      IDLE: if (!empty) begin
        cmd_d = fifo_q[rp_q];
        state_d = CHECK;
      end
      CHECK: if (!ok || acn == '0) begin
        einv_d = einv_d || !ok;
        done_d = 1'b1;
        state_d = GAP;
      end else begin
        ic_d = op;
        if (is_wr) {wbs_d, wbe_d, was_d, wac_d} = {bs, be, ast, acn};
        else {rbs_d, rbe_d, ras_d, rac_d} = {bs[2:0], be[2:0], ast, acn};
        state_d = WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (hit) begin
          ic_d = 8'h00;
          done_d = 1'b1;
          state_d = GAP;
        end else if (tmo_hit) begin
          ic_d = 8'h00;
          etmo_d = 1'b1;
          state_d = ERROR;
        end
      end
      GAP: begin
        gap_d = gap_q + GW'(1);
        state_d = gap_q == GW'(GAP_CYCLES - 1) ? IDLE : GAP;
      end
      ERROR: if (clear_err) begin
        etmo_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      cmd_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      gap_q <= '0;
      tmo_q <= '0;
      ic_q <= '0;
      {wbs_q, wbe_q, was_q, wac_q} <= '0;
      {rbs_q, rbe_q, ras_q, rac_q} <= '0;
      {done_q, einv_q, etmo_q} <= '0;
    end else begin
      if (push) fifo_q[wp_q] <= {bus.cmd_tdata[63:56], bus.cmd_tdata[52:48], bus.cmd_tdata[44:40], bus.cmd_tdata[31:0]};
      wp_q <= wp_q + AW'(push);
      rp_q <= rp_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      state_q <= state_d;
      cmd_q <= cmd_d;
      gap_q <= gap_d;
      tmo_q <= tmo_d;
      ic_q <= ic_d;
      {wbs_q, wbe_q, was_q, wac_q} <= {wbs_d, wbe_d, was_d, wac_d};
      {rbs_q, rbe_q, ras_q, rac_q} <= {rbs_d, rbe_d, ras_d, rac_d};
      {done_q, einv_q, etmo_q} <= {done_d, einv_d, etmo_d};
    end
  end
endmodule
